booth_mult_unit: RTL and testbench
==================================

// Module: booth_mult_unit
// PURPOSE
//   Multicycle signed 32x32 multiplier built around a 65-bit product register {A[31:0], Q[31:0], Qm1}.
//   Radix-2 Booth: one add/sub plus arithmetic right shift per cycle; sole writer and consumer of that register.
//   Sits in the execute stage beside the ALU; the pipeline stalls on busy and takes the result on data_resultRDY.
// PARAMETERS
//   WIDTH    32  operand/result width; product register is 2*WIDTH+1 bits
//   ITERS    32  Booth iterations per multiply (= WIDTH)
//   CNT_W    6   iteration counter width (>= clog2(ITERS+1))
// PORTS
//   clock            in   1   rising-edge clock
//   ctrl_reset       in   1   asynchronous, active-high reset
//   ctrl_MULT        in   1   start pulse; samples operands on this edge
//   data_operandA    in   32  multiplicand M (signed)
//   data_operandB    in   32  multiplier (signed), loaded into Q
//   data_result      out  32  low 32 bits of product; held until next start
//   data_exception   out  1   1 = 64-bit product not representable in 32 bits; valid with data_resultRDY
//   data_resultRDY   out  1   one-cycle pulse: result/exception valid
//   busy             out  1   high in RUN; stall request to pipeline
// BEHAVIOUR
//   Reset (async, any time incl. mid-multiply): state=IDLE, product reg=0, M=0, count=0,
//     data_result=0, data_exception=0, data_resultRDY=0, busy=0. In-flight op discarded, no RDY.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on edge with ctrl_MULT=1: M<=operandA, P<={32'b0, operandB, 1'b0}, count<=0, go RUN.
//   RUN (busy=1): per edge, by {Q[0],Qm1}: 01 -> A+M; 10 -> A-M; 00/11 -> A unchanged.
//     Sum computed 33 bits wide; bit 32 of the sum (true sign) is the bit shifted into P[64]
//     so M=0x80000000 never corrupts the sign. Then P <= {sign33, sum[31:0], Q} >> 1 (65-bit shift).
//     count++; after ITERS-th iteration go DONE.
//   DONE: data_resultRDY=1 for exactly one cycle, then IDLE on next edge.
//   Latency: start edge = edge 0; iterations on edges 1..32; RDY high in cycle after edge 32; IDLE after edge 33.
//   data_result = P[32:1]; data_exception = ~(P[64:33] all equal P[32]) i.e. upper half not sign-extension.
//   Outputs combinational from P/state; stable between starts.
//   ctrl_MULT in RUN or DONE: restart; reload operands, count=0, state RUN; old op abandoned, no RDY for it.
//   ctrl_MULT and ctrl_reset together: reset wins.
//   Operands only sampled on start edge; changes during RUN ignored.
// CONFIGURATION
//   BOOTH_MULT_EARLY_ZERO_EN defined: if operandA==0 or operandB==0 at start, load P=0 and go straight
//     to DONE; RDY in cycle after edge 0, result 0, exception 0, busy never asserted.
//   Not defined: every multiply takes full 32-iteration latency, including zero operands.
// STRUCTURE
//   Shared header multdiv_defs.vh: state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2), MULT_ITERS,
//     product-register field offsets (A_MSB=64, A_LSB=33, Q_MSB=32, Q_LSB=1, QM1=0); reused by divider.
//   Sub-module booth_step: combinational; in P[64:0], M[31:0]; out next P (add/sub/shift). Top holds FSM,
//     counter, M register, product register.
// TESTING
//   3 x 4 -> RDY after edge 32, result 0x0000000C, exception 0.
//   -7 x 6 -> result 0xFFFFFFD6 (-42), exception 0; busy high exactly 32 cycles.
//   0x80000000 x 0xFFFFFFFF -> result 0x80000000, exception 1 (2^31 overflows).
//   0x00010000 x 0x00010000 -> result 0, exception 1; 0x80000000 x 1 -> 0x80000000, exception 0.
//   Start 5x5, reassert ctrl_MULT with 2x9 at iteration 10 -> single RDY, result 18, 32 cycles after restart.
//   ctrl_reset at iteration 20 -> all outputs 0 immediately, no RDY; 0 x 123 -> result 0 in 1 cycle with
//     BOOTH_MULT_EARLY_ZERO_EN, 32 cycles without.

Source files
------------

// File: rtl/booth_mult_unit_pkg.sv
// -----------------------------------------------------------------------------
// booth_mult_unit_pkg
//   Shared definitions for the Booth multiplier. The divider reuses them.
//   - FSM state encodings (S_IDLE / S_RUN / S_DONE)
//   - default datapath sizes (DEF_WIDTH, MULT_ITERS, DEF_CNT_W)
//   - field offsets inside the 65-bit product register {A, Q, Qm1}
//   - Booth recoding of the {Q[0], Qm1} bit pair
// -----------------------------------------------------------------------------
package booth_mult_unit_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int MULT_ITERS = 32;
    localparam int DEF_CNT_W  = 6;

    // Product register layout for the default 32-bit datapath.
    localparam int A_MSB = 64;
    localparam int A_LSB = 33;
    localparam int Q_MSB = 32;
    localparam int Q_LSB = 1;
    localparam int QM1   = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding: 01 ends a run of ones (add M),
    // 10 starts a run of ones (subtract M), 00/11 are inside a run.
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        booth_op_t op;
        case ({q0, qm1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_unit_booth_step.sv
// -----------------------------------------------------------------------------
// booth_mult_unit_booth_step
//   One combinational radix-2 Booth iteration: add/subtract M into the A half
//   of the product register, then arithmetic-shift the whole register right.
// Ports
//   p_in   [2*WIDTH:0]  current product register {A, Q, Qm1}
//   m      [WIDTH-1:0]  multiplicand (signed)
//   p_out  [2*WIDTH:0]  product register after this iteration
// -----------------------------------------------------------------------------
module booth_mult_unit_booth_step
    import booth_mult_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH:0] p_in,
    input  logic [WIDTH-1:0] m,
    output logic [2*WIDTH:0] p_out
);

    localparam int P_A_MSB = 2 * WIDTH;
    localparam int P_A_LSB = WIDTH + 1;
    localparam int P_Q_MSB = WIDTH;
    localparam int P_Q_LSB = 1;
    localparam int P_QM1   = 0;

    booth_op_t      op;
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    always_comb begin
        op    = booth_decode(p_in[P_Q_LSB], p_in[P_QM1]);
        a_ext = {p_in[P_A_MSB], p_in[P_A_MSB:P_A_LSB]};
        m_ext = {m[WIDTH-1], m};
        case (op)
            OP_ADD:  sum = a_ext + m_ext;
            OP_SUB:  sum = a_ext - m_ext;
            default: sum = a_ext;
        endcase
        // The sum is one bit wider than A so that its top bit is the true
        // sign even when M = most-negative value; that bit is what shifts
        // into the register MSB. Dropping the old Qm1 is the right shift.
        p_out = {sum[WIDTH], sum[WIDTH-1:0], p_in[P_Q_MSB:P_Q_LSB]};
    end

endmodule

// File: rtl/booth_mult_unit.sv
// -----------------------------------------------------------------------------
// booth_mult_unit
//   Multicycle signed WIDTH x WIDTH radix-2 Booth multiplier. Holds the FSM,
//   iteration counter, multiplicand register and the 2*WIDTH+1 bit product
//   register {A, Q, Qm1}; one booth_step iteration per clock in RUN.
//   Latency: start edge 0, iterations on edges 1..ITERS, data_resultRDY high
//   in the cycle after edge ITERS, back to IDLE on the following edge.
//   Optional build macro BOOTH_MULT_EARLY_ZERO_EN: a zero operand at start
//   skips the iterations and goes straight to DONE with a zero product.
// Ports
//   clock           rising-edge clock
//   ctrl_reset      asynchronous active-high reset
//   ctrl_MULT       start pulse; operands sampled on this edge (restarts if busy)
//   data_operandA   multiplicand M (signed)
//   data_operandB   multiplier (signed), loaded into Q
//   data_result     low WIDTH bits of the product, held until the next start
//   data_exception  product does not fit in WIDTH bits; valid with data_resultRDY
//   data_resultRDY  one-cycle pulse, result/exception valid
//   busy            high while iterating (pipeline stall request)
// -----------------------------------------------------------------------------
module booth_mult_unit
    import booth_mult_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITERS = WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int P_W = 2 * WIDTH + 1;

    state_t           state_reg;
    logic [P_W-1:0]   p_reg;
    logic [P_W-1:0]   p_next;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] count_reg;
    logic             last_iter;
    logic             start_zero;
    logic [WIDTH-1:0] ext_diff;

    booth_mult_unit_booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_in  (p_reg),
        .m     (m_reg),
        .p_out (p_next)
    );

    assign last_iter = (count_reg == CNT_W'(ITERS - 1));

`ifdef BOOTH_MULT_EARLY_ZERO_EN
    // A zero operand makes the product zero; no need to iterate.
    assign start_zero = (data_operandA == '0) || (data_operandB == '0);
`else
    assign start_zero = 1'b0;
`endif

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_reg <= S_IDLE;
            p_reg     <= '0;
            m_reg     <= '0;
            count_reg <= '0;
        end else if (ctrl_MULT) begin
            // Start from any state; an in-flight multiply is abandoned.
            m_reg     <= data_operandA;
            count_reg <= '0;
            if (start_zero) begin
                p_reg     <= '0;
                state_reg <= S_DONE;
            end else begin
                p_reg     <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                state_reg <= S_RUN;
            end
        end else begin
            case (state_reg)
                S_RUN: begin
                    p_reg     <= p_next;
                    count_reg <= count_reg + CNT_W'(1);
                    if (last_iter) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Overflow: the upper half is not just the sign extension of the result.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ext
            assign ext_diff[gi] = p_reg[WIDTH + 1 + gi] ^ p_reg[WIDTH];
        end
    endgenerate

    assign data_result    = p_reg[WIDTH:1];
    assign data_exception = |ext_diff;
    assign data_resultRDY = (state_reg == S_DONE);
    assign busy           = (state_reg == S_RUN);

endmodule

// File: tb/tb_booth_mult_unit.sv
module tb_booth_mult_unit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int pass_cnt;
    int total_cnt;
    int rdy_cnt;
    int rdy_edge;
    int busy_cnt;
    logic [31:0] res_at_rdy;
    logic        exc_at_rdy;
    vec_t vecs[13];

    booth_mult_unit dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("ok   %s = 0x%0h", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: present operands, pulse start across one posedge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1 ctrl_MULT = 1'b0;
    endtask

    task automatic sample(input int edge_idx);
        if (busy) busy_cnt++;
        if (data_resultRDY) begin
            rdy_cnt++;
            rdy_edge   = edge_idx;
            res_at_rdy = data_result;
            exc_at_rdy = data_exception;
        end
    endtask

    // Observe the cycle after the start edge and n more; operands are
    // scrambled every cycle to show they are not re-sampled while running.
    task automatic collect(input int n);
        rdy_cnt  = 0;
        rdy_edge = -1;
        busy_cnt = 0;
        @(negedge clock);
        sample(0);
        for (int i = 1; i <= n; i++) begin
            @(posedge clock);
            #1;
            data_operandA = $urandom;
            data_operandB = $urandom;
            @(negedge clock);
            sample(i);
        end
    endtask

    initial begin
        int exp_edge;
        int exp_busy;
        clock          = 1'b0;
        ctrl_reset     = 1'b1;
        ctrl_MULT      = 1'b0;
        data_operandA  = '0;
        data_operandB  = '0;
        pass_cnt       = 0;
        total_cnt      = 0;

        vecs[0]  = '{32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 1'b0};
        vecs[1]  = '{32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6, 1'b0};
        vecs[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[3]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[6]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
        vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[8]  = '{32'h0000_0000, 32'h0000_0123, 32'h0000_0000, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[10] = '{32'hFFFF_FF9C, 32'h0000_00C8, 32'hFFFF_B1E0, 1'b0};
        vecs[11] = '{32'h0000_B505, 32'h0000_B505, 32'h8000_1219, 1'b1};
        vecs[12] = '{32'h0000_0123, 32'h0000_0000, 32'h0000_0000, 1'b0};

        // Asynchronous reset acts before any clock edge.
        #1;
        check("reset_outputs", {28'd0, data_result, data_exception, data_resultRDY, busy}, 64'd0);
        repeat (2) @(negedge clock);
        ctrl_reset = 1'b0;

        foreach (vecs[i]) begin
            exp_edge = 32;
            exp_busy = 32;
`ifdef BOOTH_MULT_EARLY_ZERO_EN
            if (vecs[i].a == 32'd0 || vecs[i].b == 32'd0) begin
                exp_edge = 0;
                exp_busy = 0;
            end
`endif
            start_op(vecs[i].a, vecs[i].b);
            collect(40);
            check($sformatf("v%0d_rdy_count", i), 64'(rdy_cnt), 64'd1);
            check($sformatf("v%0d_rdy_edge", i), 64'(rdy_edge), 64'(exp_edge));
            check($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt), 64'(exp_busy));
            check($sformatf("v%0d_result", i), 64'(res_at_rdy), 64'(vecs[i].res));
            check($sformatf("v%0d_exception", i), 64'(exc_at_rdy), 64'(vecs[i].exc));
            check($sformatf("v%0d_result_held", i), 64'(data_result), 64'(vecs[i].res));
        end

        // Restart mid-multiply: 5x5 abandoned, only 2x9 completes.
        start_op(32'd5, 32'd5);
        collect(10);
        check("restart_first_no_rdy", 64'(rdy_cnt), 64'd0);
        check("restart_first_busy", 64'(busy_cnt), 64'd11);
        start_op(32'd2, 32'd9);
        collect(40);
        check("restart_rdy_count", 64'(rdy_cnt), 64'd1);
        check("restart_rdy_edge", 64'(rdy_edge), 64'd32);
        check("restart_result", 64'(res_at_rdy), 64'd18);
        check("restart_exception", 64'(exc_at_rdy), 64'd0);

        // Reset in the middle of a multiply clears everything at once.
        start_op(32'd7, 32'd7);
        collect(20);
        check("midreset_busy_before", 64'(busy), 64'd1);
        ctrl_reset = 1'b1;
        #1;
        check("midreset_outputs", {28'd0, data_result, data_exception, data_resultRDY, busy}, 64'd0);
        #1 ctrl_reset = 1'b0;
        collect(40);
        check("midreset_no_rdy", 64'(rdy_cnt), 64'd0);
        check("midreset_no_busy", 64'(busy_cnt), 64'd0);

        // Reset and start together: reset wins.
        ctrl_reset    = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        @(posedge clock);
        #1;
        check("reset_beats_start", {30'd0, data_result, data_resultRDY, busy}, 64'd0);
        ctrl_MULT = 1'b0;
        @(negedge clock);
        ctrl_reset = 1'b0;
        collect(5);
        check("reset_beats_start_idle", 64'(busy_cnt + rdy_cnt), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
